adsr_envelope: RTL

//  ADSR amplitude envelope applied to the selected 11-bit voice waveform (offset binary, midscale 1024).

---
 rtl/adsr_envelope_if.sv | 47 ++++
 rtl/adsr_envelope.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/adsr_envelope_if.sv
// ---------------------------------------------------------------------------
// adsr_envelope_if
//   Bundles the envelope generator's control, waveform and status signals.
//   Clock and reset stay outside the interface as plain ports of the module.
//
//   master : drives tick/gate/rates/sustain/wave_in, observes the outputs
//   slave  : the envelope generator itself
//
//   tick           sample-rate enable strobe, 1 clk wide
//   gate           key held (level)
//   attack_rate    env increment per tick in ATTACK
//   decay_rate     env decrement per tick in DECAY
//   sustain_level  SUSTAIN hold level
//   release_rate   env decrement per tick in RELEASE
//   wave_in        selected waveform sample, offset binary
//   wave_out       enveloped sample, registered
//   env_level      current envelope level
//   env_state      IDLE=0 ATTACK=1 DECAY=2 SUSTAIN=3 RELEASE=4
//   busy           env_state != IDLE
// ---------------------------------------------------------------------------
interface adsr_envelope_if #(
  parameter int DATA_W = 11,
  parameter int ENV_W  = 12,
  parameter int RATE_W = 8
);
  logic              tick;
  logic              gate;
  logic [RATE_W-1:0] attack_rate;
  logic [RATE_W-1:0] decay_rate;
  logic [ENV_W-1:0]  sustain_level;
  logic [RATE_W-1:0] release_rate;
  logic [DATA_W-1:0] wave_in;
  logic [DATA_W-1:0] wave_out;
  logic [ENV_W-1:0]  env_level;
  logic [2:0]        env_state;
  logic              busy;

  modport master (
    output tick, gate, attack_rate, decay_rate, sustain_level, release_rate, wave_in,
    input  wave_out, env_level, env_state, busy
  );

  modport slave (
    input  tick, gate, attack_rate, decay_rate, sustain_level, release_rate, wave_in,
    output wave_out, env_level, env_state, busy
  );
endinterface

// File: rtl/adsr_envelope.sv
// ---------------------------------------------------------------------------
// adsr_envelope
//   ADSR amplitude envelope applied to an offset-binary voice waveform
//   (midscale = silence). A 5-state FSM steps the envelope level on
//   sample-rate ticks under key-gate control; every clk the waveform is
//   scaled about midscale by the current level and registered.
//
//   Ports:
//     clk   system clock
//     rst   synchronous, active-high reset
//     bus   adsr_envelope_if.slave (tick, gate, rates, sustain_level,
//           wave_in in; wave_out, env_level, env_state, busy out)
//
//   Configuration macro:
//     ENV_EXP_RELEASE_EN  defined  : exponential release,
//                                    step = max(env >> release_rate[3:0], 1)
//                         undefined: linear release, step = release_rate
// ---------------------------------------------------------------------------
module adsr_envelope #(
  parameter int DATA_W = 11,
  parameter int ENV_W  = 12,
  parameter int RATE_W = 8
) (
  input logic             clk,
  input logic             rst,
  adsr_envelope_if.slave  bus
);

  localparam int EW = ENV_W + 1;           // envelope arithmetic width, no wrap
  localparam int SW = DATA_W + 1;          // signed sample width
  localparam int PW = SW + ENV_W + 1;      // product width

  localparam logic [EW-1:0]     ENV_MAX = EW'((1 << ENV_W) - 1);
  localparam logic [DATA_W-1:0] MID     = DATA_W'(1 << (DATA_W - 1));

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ATTACK  = 3'd1,
    DECAY   = 3'd2,
    SUSTAIN = 3'd3,
    RELEASE = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [ENV_W-1:0]  env_q, env_d;
  logic              gate_q;
  logic [DATA_W-1:0] wave_q;

  logic              rise, fall;
  logic [EW-1:0]     env_x, sus_x, att_sum, dec_floor, rel_step;
  logic              rel_done;

  assign rise = bus.gate & ~gate_q;
  assign fall = ~bus.gate & gate_q;

  assign env_x   = {1'b0, env_q};
  assign sus_x   = {1'b0, bus.sustain_level};
  assign att_sum = env_x + EW'(bus.attack_rate);
  // env - decay <= sustain is evaluated as env <= sustain + decay so the
  // comparison never underflows.
  assign dec_floor = sus_x + EW'(bus.decay_rate);

`ifdef ENV_EXP_RELEASE_EN
  logic [EW-1:0] rel_shift;
  assign rel_shift = env_x >> bus.release_rate[3:0];
  assign rel_step  = (rel_shift == '0) ? EW'(1) : rel_shift;
`else
  assign rel_step  = EW'(bus.release_rate);
`endif

  // A zero step only occurs for linear release_rate==0, which releases at once.
  assign rel_done = (rel_step == '0) || (rel_step >= env_x);

  // NOTE: every variable written here gets a default first, so no path
  // through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    env_d   = env_q;
    if (rise) begin
      state_d = ATTACK;                    // retrigger keeps the current level
    end else if (fall && (state_q inside {ATTACK, DECAY, SUSTAIN})) begin
      state_d = RELEASE;
    end else if (bus.tick) begin
      case (state_q)
        IDLE: env_d = '0;
        ATTACK: begin
          if ((bus.attack_rate == '0) || (att_sum >= ENV_MAX)) begin
            env_d   = ENV_MAX[ENV_W-1:0];
            state_d = DECAY;
          end else begin
            env_d = att_sum[ENV_W-1:0];
          end
        end
        DECAY: begin
          if ((bus.decay_rate == '0) || (env_x <= dec_floor)) begin
            env_d   = bus.sustain_level;
            state_d = SUSTAIN;
          end else begin
            env_d = env_q - ENV_W'(bus.decay_rate);
          end
        end
        SUSTAIN: env_d = bus.sustain_level;
        RELEASE: begin
          if (rel_done) begin
            env_d   = '0;
            state_d = IDLE;
          end else begin
            env_d = env_q - rel_step[ENV_W-1:0];
          end
        end
        default: begin
          env_d   = '0;
          state_d = IDLE;
        end
      endcase
    end
  end

  // Scale about midscale: (wave_in - MID) * env / 2**ENV_W, floored.
  logic signed [SW-1:0] s;
  logic signed [PW-1:0] s_x, e_x, prod;

  assign s    = $signed({1'b0, bus.wave_in}) - $signed({1'b0, MID});
  assign s_x  = PW'(s);
  assign e_x  = PW'({1'b0, env_q});
  assign prod = s_x * e_x;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    gate_q <= bus.gate;                    // tracks gate through reset: no rise on release of rst
    if (rst) begin
      state_q <= IDLE;
      env_q   <= '0;
      wave_q  <= MID;
    end else begin
      state_q <= state_d;
      env_q   <= env_d;
      wave_q  <= DATA_W'(prod >>> ENV_W) + MID;
    end
  end

  assign bus.wave_out  = wave_q;
  assign bus.env_level = env_q;
  assign bus.env_state = state_q;
  assign bus.busy      = (state_q != IDLE);

endmodule
